multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Parametrised multi-cycle control unit with program counter (PC) and instruction register (IR) for the R/I/J MIPS-subset CPU.
- Sequences fetch, decode, execute, memory and write-back phases, and drives the datapath (register file, ALU, data memory) through control strobes.
- Adds ready/req memory handshakes with wait states and a bus-timeout trap; the single-cycle control has neither.

Parameters:
- ADDR_W, 32, PC and memory address width (16..32).
- RESET_PC, 0, PC value loaded on reset; must be word aligned.
- MEM_TIMEOUT, 15, maximum wait cycles on any memory request before trap (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ready  in  1  data access complete this cycle.
- alu_zero  in  1  ALU zero flag from the datapath.
- pc  out  ADDR_W  current PC.
- ir  out  32  latched instruction.
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 funct-decode.
- alu_src_b  out  1  0 = rt register, 1 = extended immediate.
- imm_zext  out  1  1 = zero-extend immediate (andi/ori).
- reg_dst  out  1  0 = rt, 1 = rd (31 for jal is forced by link).
- reg_we  out  1  register-file write strobe, single cycle.
- mem_to_reg  out  1  write-back source = load data.
- link  out  1  write pc to r31 (jal).
- state_o  out  4  current state encoding, for debug.
- illegal  out  1  one-cycle pulse on unknown opcode.
- bus_err  out  1  sticky timeout flag.

Behaviour:
Reset:
- While rst=0: state=FETCH, pc=RESET_PC, ir=0, wait counter=0.
- All strobes 0, bus_err=0, alu_op=0.

States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 15.

FETCH:
- imem_req=1 until imem_ready.
- On imem_ready: ir<=imem_rdata, pc<=pc+4, go to DECODE.

DECODE decodes opcode = ir[31:26]:
- 000000 -> EXEC_R.
- 001000 addi, 001100 andi, 001101 ori, 001010 slti -> EXEC_I.
- 100011 lw, 101011 sw -> MEM_ADDR.
- 000100 beq, 000101 bne -> BRANCH.
- 000010 j, 000011 jal -> JUMP.
- Any other opcode: illegal pulses 1 cycle, go to FETCH; pc already advanced.

Datapath phases:
- EXEC_R: alu_op=5 -> WB_R (reg_we=1, reg_dst=1) -> FETCH.
- EXEC_I: alu_src_b=1; alu_op add/and/or/slt per opcode; imm_zext=1 for andi/ori -> WB_I (reg_we=1, reg_dst=0) -> FETCH.
- MEM_ADDR: alu_op=0, alu_src_b=1 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD / MEM_WR: dmem_req=1 held until dmem_ready; dmem_we=1 in MEM_WR. On ready, MEM_RD -> WB_MEM (reg_we=1, mem_to_reg=1); MEM_WR -> FETCH.
- BRANCH: alu_op=1. Taken if (beq & alu_zero) or (bne & !alu_zero). When taken, pc<=pc+(sext(ir[15:0])<<2), truncated to ADDR_W. -> FETCH.
- JUMP: pc low 28 bits <= {ir[25:0],2'b00}; upper ADDR_W-28 bits unchanged if ADDR_W>28, else truncate. jal: link=1 and reg_we=1 in the same cycle, pc value before update. -> FETCH.

Latency with zero wait states, counting the fetch cycle:
- R, I, sw: 4 cycles. lw: 5. branch, jump: 3. Illegal: 2.
- Each wait cycle adds 1.

Timeout:
- Counter clears on entry to each request state and counts each cycle the request is not answered.
- When the count reaches MEM_TIMEOUT without ready: go to TRAP, bus_err<=1.
- TRAP holds all strobes 0; exit only by reset.
- A ready arriving on the same cycle the count would expire wins: no trap.

Other rules:
- Strobes are Moore outputs decoded from state and ir; there is no combinational path from ready to req.
- Reset asserted mid-request drops req asynchronously.
- pc wraps modulo 2^ADDR_W.

Optional Feature:
- PERF_CNT_EN defined: adds outputs cyc_cnt[31:0] and ins_cnt[31:0], both reset to 0.
  - cyc_cnt increments every cycle outside TRAP.
  - ins_cnt increments on each entry to FETCH from a non-reset state, including illegal.
  - Both wrap at 2^32.
- Not defined: ports and logic absent, and all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0x100, imem_ready=1 immediately, ir=0x012A4020 (add $8,$9,$10) -> imem_addr=0x100; state sequence 0,1,2,7; reg_we=1 with reg_dst=1 in cycle 4; pc=0x104.
- lw 0x8D280004, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; WB_MEM asserts reg_we and mem_to_reg; 8 cycles total.
- beq 0x1109FFFF at pc=0x200 with alu_zero=1 -> pc=0x200; same instruction with alu_zero=0 -> pc=0x204.
- jal 0x0C000040 at pc=0x300, ADDR_W=32 -> link=1 and reg_we=1 in the JUMP cycle; next pc=0x00000100.
- imem_ready held 0 with MEM_TIMEOUT=15 -> bus_err=1 and state_o=15 after 15 wait cycles; ready on wait 15 instead -> no trap; rst low clears bus_err.
- Opcode 0x3F -> illegal pulses once; next fetch at pc+4; ins_cnt increments by 1 with PERF_CNT_EN defined.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: PC/IR, phase sequencing, req/ready memory handshakes, bus timeout trap.
// Optional PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [2:0]        alu_op,
    output logic              alu_src_b,
    output logic              imm_zext,
    output logic              reg_dst,
    output logic              reg_we,
    output logic              mem_to_reg,
    output logic              link,
    output logic [3:0]        state_o,
    output logic              illegal,
    output logic              bus_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ins_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // Trap is taken in the cycle the unanswered count would reach MEM_TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [7:0]          r_wait;
    logic                r_bus_err;

    logic [5:0]          w_op;
    logic                w_op_i;
    logic                w_op_bad;
    logic                w_taken;
    logic                w_to_fetch;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_br_pc;
    logic [ADDR_W-1:0]   w_jump_pc;

    assign w_op     = r_ir[31:26];
    assign w_op_i   = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_SLTI);
    assign w_op_bad = !((w_op == OP_R) || w_op_i || (w_op == OP_LW) || (w_op == OP_SW) ||
                        (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_J) || (w_op == OP_JAL));
    assign w_taken  = ((w_op == OP_BEQ) && alu_zero) || ((w_op == OP_BNE) && !alu_zero);
    assign w_pc_inc = r_pc + ADDR_W'(4);
    assign w_br_pc  = r_pc + ADDR_W'({{14{r_ir[15]}}, r_ir[15:0], 2'b00});

    generate
        if (ADDR_W > 28) begin : g_jump_hi
            assign w_jump_pc = {r_pc[ADDR_W-1:28], r_ir[25:0], 2'b00};
        end else begin : g_jump_lo
            logic [27:0] w_jfull;
            assign w_jfull   = {r_ir[25:0], 2'b00};
            assign w_jump_pc = w_jfull[ADDR_W-1:0];
        end
    endgenerate

    // Cycles that retire an instruction (or discard an illegal one) and re-enter FETCH.
    assign w_to_fetch = ((r_state == S_DECODE) && w_op_bad) ||
                        (r_state == S_WB_R) || (r_state == S_WB_I) || (r_state == S_WB_MEM) ||
                        (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                        ((r_state == S_MEM_WR) && dmem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_wait    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            // Only request states keep the counter; everywhere else it sits at zero,
            // so it is clear on entry to every request state.
            r_wait <= '0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= w_pc_inc;
                        r_state <= S_DECODE;
                    end else if (r_wait == TO_LAST) begin
                        r_state   <= S_TRAP;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_R)                             r_state <= S_EXEC_R;
                    else if (w_op_i)                              r_state <= S_EXEC_I;
                    else if ((w_op == OP_LW) || (w_op == OP_SW))  r_state <= S_MEM_ADDR;
                    else if ((w_op == OP_BEQ) || (w_op == OP_BNE)) r_state <= S_BRANCH;
                    else if ((w_op == OP_J) || (w_op == OP_JAL))  r_state <= S_JUMP;
                    else                                          r_state <= S_FETCH;
                end
                S_EXEC_R:   r_state <= S_WB_R;
                S_EXEC_I:   r_state <= S_WB_I;
                S_MEM_ADDR: r_state <= (w_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD, S_MEM_WR: begin
                    if (dmem_ready) begin
                        r_state <= (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                    end else if (r_wait == TO_LAST) begin
                        r_state   <= S_TRAP;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_WB_R, S_WB_I, S_WB_MEM: r_state <= S_FETCH;
                S_BRANCH: begin
                    if (w_taken) r_pc <= w_br_pc;
                    r_state <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc    <= w_jump_pc;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Moore strobes; gating with rst drops any request the moment reset asserts.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_op     = 3'd0;
        alu_src_b  = 1'b0;
        imm_zext   = 1'b0;
        reg_dst    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            case (r_state)
                S_FETCH:  imem_req = 1'b1;
                S_DECODE: illegal  = w_op_bad;
                S_EXEC_R: alu_op   = 3'd5;
                S_EXEC_I: begin
                    alu_src_b = 1'b1;
                    imm_zext  = (w_op == OP_ANDI) || (w_op == OP_ORI);
                    case (w_op)
                        OP_ANDI: alu_op = 3'd2;
                        OP_ORI:  alu_op = 3'd3;
                        OP_SLTI: alu_op = 3'd4;
                        default: alu_op = 3'd0;
                    endcase
                end
                S_MEM_ADDR: alu_src_b = 1'b1;
                S_MEM_RD:   dmem_req  = 1'b1;
                S_MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                end
                S_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                end
                S_WB_I:   reg_we = 1'b1;
                S_WB_MEM: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: alu_op = 3'd1;
                S_JUMP: begin
                    link   = (w_op == OP_JAL);
                    reg_we = (w_op == OP_JAL);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign state_o   = r_state;
    assign bus_err   = r_bus_err;

`ifdef PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ins_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            if (r_state != S_TRAP) r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_to_fetch)        r_ins_cnt <= r_ins_cnt + 32'd1;
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ins_cnt = r_ins_cnt;
`else
    logic w_unused;
    assign w_unused = w_to_fetch;
`endif

endmodule
